// File: rtl/yuv_pkg.sv
// Shared constants and scheduler state encoding for the YUV macroblock-row read path.
package yuv_pkg;

  localparam int MB_COLS    = 80;
  localparam int Y_WORDS    = 64;
  localparam int UV_WORDS   = 32;
  localparam int MB_WORDS   = Y_WORDS + UV_WORDS;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ENC,
    ST_READ,
    ST_DRAIN,
    ST_WAIT_DONE,
    ST_ROW_END
  } sched_state_e;

endpackage

// File: rtl/mb_skid_fifo.sv
// Two-entry skid FIFO between the buffer read port and the encoder word interface.
module mb_skid_fifo #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [1:0]       count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign count_o = count_q;
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; occupancy is tracked by the
  // reset pointers/count and the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/mb_read_sched.sv
// Walks a stored macroblock row, issuing Y then UV word reads per macroblock and
// forwarding returned words to the encoder through a 2-entry skid buffer.
module mb_read_sched #(
  parameter int MB_COLS      = 80,
  parameter int Y_WORDS      = 64,
  parameter int UV_WORDS     = 32,
  parameter int ADDR_WIDTH   = 7,
  parameter int MB_CNT_WIDTH = 7,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    buf_valid_i,
  output logic                    rd_ready_o,
  output logic [ADDR_WIDTH-1:0]   rd_addr_o,
  input  logic                    rd_data_valid_i,
  input  logic [DATA_WIDTH-1:0]   rd_data_i,
  input  logic                    enc_ready_i,
  output logic                    mb_start_o,
  output logic [MB_CNT_WIDTH-1:0] mb_x_o,
  output logic                    pix_valid_o,
  input  logic                    pix_ready_i,
  output logic [DATA_WIDTH-1:0]   pix_data_o,
  output logic                    pix_uv_o,
  output logic                    pix_last_o,
  input  logic                    enc_done_i,
  output logic                    row_done_o,
  output logic                    busy_o,
  output logic                    err_o
);

  import yuv_pkg::*;

  localparam int SKID_W = DATA_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0]   LAST_IDX = ADDR_WIDTH'(Y_WORDS + UV_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0]   FIRST_UV = ADDR_WIDTH'(Y_WORDS);
  localparam logic [MB_CNT_WIDTH-1:0] LAST_MB  = MB_CNT_WIDTH'(MB_COLS - 1);

  sched_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [MB_CNT_WIDTH-1:0] mb_x_q, mb_x_d;
  logic                    inflight_q, inflight_d;
  logic [1:0]              tag_q, tag_d;
  logic                    last_acc_q, last_acc_d;
  logic                    row_done_q, row_done_d;
  logic                    err_q, err_d;

  logic [1:0]        skid_count;
  logic              skid_full;
  logic              skid_empty;
  logic [SKID_W-1:0] skid_head;
  logic              issue;
  logic              push;
  logic              pop;
  logic              spurious;
  logic              overflow;
  logic              mb_start;

  // Returned data is only accepted when a read is outstanding; stray beats are dropped and flagged.
  assign push     = rd_data_valid_i & inflight_q;
  assign spurious = rd_data_valid_i & ~inflight_q;
  assign pop      = ~skid_empty & pix_ready_i;
  assign overflow = push & skid_full & ~pop;
  assign issue    = (state_q == ST_READ) &&
                    (({1'b0, skid_count} + {2'b00, inflight_q}) < 3'd2);

  mb_skid_fifo #(
    .WIDTH (SKID_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({tag_q, rd_data_i}),
    .dout_o  (skid_head),
    .count_o (skid_count),
    .full_o  (skid_full),
    .empty_o (skid_empty)
  );

  // NOTE: every always_comb target gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mb_x_d     = mb_x_q;
    inflight_d = inflight_q;
    tag_d      = tag_q;
    last_acc_d = last_acc_q;
    row_done_d = 1'b0;
    err_d      = err_q | spurious | overflow;
    mb_start   = 1'b0;

    // The uv/last tag is captured at issue and rides with the returning word.
    if (issue) begin
      inflight_d = 1'b1;
      tag_d      = {idx_q == LAST_IDX, idx_q >= FIRST_UV};
    end else if (rd_data_valid_i) begin
      inflight_d = 1'b0;
    end
    if (pop && skid_head[SKID_W-1]) last_acc_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (buf_valid_i) state_d = ST_WAIT_ENC;
      end
      ST_WAIT_ENC: begin
        if (enc_ready_i) begin
          mb_start   = 1'b1;
          idx_d      = '0;
          last_acc_d = 1'b0;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        if (issue) begin
          if (idx_q == LAST_IDX) state_d = ST_DRAIN;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && skid_empty && last_acc_q) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (enc_done_i) begin
          if (mb_x_q == LAST_MB) begin
            mb_x_d     = '0;
            row_done_d = 1'b1;
            state_d    = ST_ROW_END;
          end else begin
            mb_x_d  = mb_x_q + 1'b1;
            state_d = ST_WAIT_ENC;
          end
        end
      end
      ST_ROW_END: begin
        if (!buf_valid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      mb_x_q     <= '0;
      inflight_q <= 1'b0;
      tag_q      <= 2'b00;
      last_acc_q <= 1'b0;
      row_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mb_x_q     <= mb_x_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      last_acc_q <= last_acc_d;
      row_done_q <= row_done_d;
      err_q      <= err_d;
    end
  end

  assign rd_ready_o  = issue;
  assign rd_addr_o   = issue ? idx_q : '0;
  assign mb_start_o  = mb_start;
  assign mb_x_o      = mb_x_q;
  assign pix_valid_o = ~skid_empty;
  assign {pix_last_o, pix_uv_o, pix_data_o} = skid_head;
  assign row_done_o  = row_done_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_mb_read_sched.sv
// Directed bench for mb_read_sched: buffer responder, encoder model and word-order monitor.
module tb_mb_read_sched;

  localparam int AW = 7;
  localparam int MW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          buf_valid_i = 1'b0;
  logic          rd_ready_o;
  logic [AW-1:0] rd_addr_o;
  logic          rd_data_valid_i = 1'b0;
  logic [DW-1:0] rd_data_i = '0;
  logic          enc_ready_i = 1'b0;
  logic          mb_start_o;
  logic [MW-1:0] mb_x_o;
  logic          pix_valid_o;
  logic          pix_ready_i = 1'b0;
  logic [DW-1:0] pix_data_o;
  logic          pix_uv_o;
  logic          pix_last_o;
  logic          enc_done_i = 1'b0;
  logic          row_done_o;
  logic          busy_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mb_read_sched dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .buf_valid_i     (buf_valid_i),
    .rd_ready_o      (rd_ready_o),
    .rd_addr_o       (rd_addr_o),
    .rd_data_valid_i (rd_data_valid_i),
    .rd_data_i       (rd_data_i),
    .enc_ready_i     (enc_ready_i),
    .mb_start_o      (mb_start_o),
    .mb_x_o          (mb_x_o),
    .pix_valid_o     (pix_valid_o),
    .pix_ready_i     (pix_ready_i),
    .pix_data_o      (pix_data_o),
    .pix_uv_o        (pix_uv_o),
    .pix_last_o      (pix_last_o),
    .enc_done_i      (enc_done_i),
    .row_done_o      (row_done_o),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  // Stimulus controls written only by the test tasks.
  int ready_mode = 0;
  int inject_req = 0;

  // Monitor statistics, written only by the monitor.
  int starts, bad_mbx, bad_start, words, bad_word, uv_words, row_dones, viol;
  int issued, popped, exp_idx, exp_mbx, cur_mb, lasts;
  bit prev_start;
  logic [DW-1:0] exp_word;

  // Buffer read port: data for a strobe seen in cycle N appears in cycle N+1.
  logic          pend_v = 1'b0;
  logic [DW-1:0] pend_d = '0;
  always @(negedge clk) begin
    pend_v = rd_ready_o;
    pend_d = 32'hA500_0000 | (32'(mb_x_o) << 8) | 32'(rd_addr_o);
  end

  // Input driver: read data, encoder ready pattern, enc_done three cycles after each last word.
  int inject_ack = 0;
  int lasts_seen = 0;
  int done_cd = 0;
  int cyc = 0;
  always @(posedge clk) begin
    #1;
    rd_data_valid_i = pend_v | (inject_req != inject_ack);
    rd_data_i       = (inject_req != inject_ack) ? 32'hDEAD_BEEF : pend_d;
    inject_ack      = inject_req;
    pix_ready_i     = (ready_mode == 2) ? (cyc % 3 == 0) : (ready_mode == 1);
    cyc++;
    if (!rst_n) begin
      lasts_seen = 0;
      done_cd    = 0;
      enc_done_i = 1'b0;
    end else if (lasts != lasts_seen) begin
      lasts_seen = lasts;
      done_cd    = 2;
      enc_done_i = 1'b0;
    end else if (done_cd > 0) begin
      done_cd--;
      enc_done_i = (done_cd == 0);
    end else begin
      enc_done_i = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      starts = 0; bad_mbx = 0; bad_start = 0; words = 0; bad_word = 0;
      uv_words = 0; row_dones = 0; viol = 0; issued = 0; popped = 0;
      exp_idx = 0; exp_mbx = 0; cur_mb = 0; lasts = 0; prev_start = 1'b0;
    end else begin
      if (prev_start && !(rd_ready_o && rd_addr_o == '0)) bad_start++;
      prev_start = mb_start_o;
      if (mb_start_o) begin
        if (mb_x_o !== MW'(exp_mbx)) bad_mbx++;
        cur_mb  = exp_mbx;
        exp_mbx = (exp_mbx == 79) ? 0 : exp_mbx + 1;
        starts++;
      end
      if (rd_ready_o && (issued - popped) >= 2) viol++;
      if (rd_ready_o) issued++;
      if (pix_valid_o && pix_ready_i) begin
        exp_word = 32'hA500_0000 | (32'(cur_mb) << 8) | 32'(exp_idx);
        if (pix_data_o !== exp_word || pix_uv_o !== (exp_idx >= 64) ||
            pix_last_o !== (exp_idx == 95)) bad_word++;
        if (pix_uv_o) uv_words++;
        if (pix_last_o) lasts++;
        exp_idx = (exp_idx == 95) ? 0 : exp_idx + 1;
        words++;
        popped++;
      end
      if (row_done_o) row_dones++;
    end
  end

  task automatic do_reset();
    rst_n       = 1'b0;
    buf_valid_i = 1'b0;
    enc_ready_i = 1'b0;
    ready_mode  = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] got [11];
    string       nm  [11];
    do_reset();
    @(negedge clk);
    got = '{32'(rd_ready_o), 32'(rd_addr_o), 32'(mb_start_o), 32'(mb_x_o), 32'(pix_valid_o),
            pix_data_o, 32'(pix_uv_o), 32'(pix_last_o), 32'(row_done_o), 32'(busy_o), 32'(err_o)};
    nm  = '{"rd_ready", "rd_addr", "mb_start", "mb_x", "pix_valid", "pix_data",
            "pix_uv", "pix_last", "row_done", "busy", "err"};
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (got[i] !== 32'd0) begin
        errors++;
        $display("FAIL reset_%s got %0h want 0", nm[i], got[i]);
      end
    end
  endtask

  task automatic test_full_row();
    bit seen = 1'b0;
    buf_valid_i = 1'b1;
    enc_ready_i = 1'b1;
    ready_mode  = 1;
    for (int i = 0; i < 30000 && !seen; i++) begin
      @(negedge clk);
      if (row_done_o) seen = 1'b1;
    end
    repeat (3) @(negedge clk);
    checks++; if (!seen) begin errors++; $display("FAIL row_done_timeout got 0 want 1"); end
    checks++; if (starts !== 80) begin errors++; $display("FAIL row_starts got %0d want 80", starts); end
    checks++; if (bad_mbx !== 0) begin errors++; $display("FAIL row_mb_x_order got %0d bad want 0", bad_mbx); end
    checks++; if (bad_start !== 0) begin errors++; $display("FAIL row_start_to_addr0 got %0d bad want 0", bad_start); end
    checks++; if (words !== 7680) begin errors++; $display("FAIL row_words got %0d want 7680", words); end
    checks++; if (bad_word !== 0) begin errors++; $display("FAIL row_word_order got %0d bad want 0", bad_word); end
    checks++; if (uv_words !== 2560) begin errors++; $display("FAIL row_uv_words got %0d want 2560", uv_words); end
    checks++; if (row_dones !== 1) begin errors++; $display("FAIL row_done_count got %0d want 1", row_dones); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL row_issue_rule got %0d want 0", viol); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL row_err got %0b want 0", err_o); end
  endtask

  task automatic test_row_end();
    bit seen = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rowend_hold_busy got %0b want 1", busy_o); end
    checks++; if (starts !== 80) begin errors++; $display("FAIL rowend_no_restart got %0d want 80", starts); end
    @(posedge clk);
    #1 buf_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rowend_to_idle got %0b want 0", busy_o); end
    @(posedge clk);
    #1 buf_valid_i = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mb_start_o) seen = 1'b1;
    end
    checks++; if (!seen || mb_x_o !== '0) begin
      errors++; $display("FAIL rowend_new_row got start=%0b mb_x=%0d want start=1 mb_x=0", seen, mb_x_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    buf_valid_i = 1'b1;
    enc_ready_i = 1'b1;
    ready_mode  = 2;
    repeat (600) @(negedge clk);
    checks++; if (bad_word !== 0) begin errors++; $display("FAIL bp_word_order got %0d bad want 0", bad_word); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL bp_issue_rule got %0d want 0", viol); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL bp_err got %0b want 0", err_o); end
    checks++; if (words < 150 || starts < 2) begin
      errors++; $display("FAIL bp_progress got words=%0d starts=%0d want >=150 >=2", words, starts);
    end
  endtask

  task automatic test_enc_stall();
    bit seen_rd = 1'b0;
    do_reset();
    buf_valid_i = 1'b1;
    ready_mode  = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_ready_o) seen_rd = 1'b1;
    end
    checks++; if (seen_rd || starts !== 0) begin
      errors++; $display("FAIL stall_no_read got rd=%0b starts=%0d want 0 0", seen_rd, starts);
    end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL stall_busy got %0b want 1", busy_o); end
    @(posedge clk);
    #1 enc_ready_i = 1'b1;
    @(negedge clk);
    checks++; if (mb_start_o !== 1'b1) begin errors++; $display("FAIL stall_mb_start got %0b want 1", mb_start_o); end
    @(posedge clk);
    #1 enc_ready_i = 1'b0;
    @(negedge clk);
    checks++; if (rd_ready_o !== 1'b1 || rd_addr_o !== '0) begin
      errors++; $display("FAIL stall_first_read got rd=%0b addr=%0d want 1 0", rd_ready_o, rd_addr_o);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    @(negedge clk);
    inject_req++;
    repeat (2) @(negedge clk);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL spur_err_set got %0b want 1", err_o); end
    repeat (10) @(negedge clk);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL spur_err_sticky got %0b want 1", err_o); end
    do_reset();
    @(negedge clk);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL spur_err_clear got %0b want 0", err_o); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    bit seen  = 1'b0;
    do_reset();
    buf_valid_i = 1'b1;
    enc_ready_i = 1'b1;
    ready_mode  = 1;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (mb_x_o == MW'(5) && rd_ready_o && rd_addr_o == AW'(40)) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_reach_idx40 got 0 want 1"); end
    #1 rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({rd_ready_o, rd_addr_o, mb_start_o, mb_x_o, pix_valid_o, pix_data_o,
                   pix_uv_o, pix_last_o, row_done_o, err_o} !== '0) begin
      errors++; $display("FAIL mid_outputs_reset got rd=%0b addr=%0d mbx=%0d pv=%0b data=%0h want all 0",
                         rd_ready_o, rd_addr_o, mb_x_o, pix_valid_o, pix_data_o);
    end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_busy got %0b want 0", busy_o); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mb_start_o) seen = 1'b1;
    end
    checks++; if (!seen || mb_x_o !== '0) begin
      errors++; $display("FAIL mid_restart got start=%0b mb_x=%0d want start=1 mb_x=0", seen, mb_x_o);
    end
    repeat (200) @(negedge clk);
    checks++; if (bad_word !== 0 || words < 96 || err_o !== 1'b0) begin
      errors++; $display("FAIL mid_after_restart got bad=%0d words=%0d err=%0b want 0 >=96 0",
                         bad_word, words, err_o);
    end
  endtask

  initial begin
    test_reset();
    test_full_row();
    test_row_end();
    test_backpressure();
    test_enc_stall();
    test_spurious();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
